// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl
// Single-request APB master sequencer sitting between mem2apb_bridge and the
// peripheral APB fabric. It accepts one read or write request at a time and
// runs the SETUP/ACCESS handshake. It handles wait states, PSLVERR and a PREADY
// timeout. A level-held request must drop before the next transfer can start.
// Every output is driven straight from a flop.

module apb_master_ctrl #(
    parameter int APB_AW         = 32,
    parameter int APB_DW         = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  m_apb_pclk_i,
    input  logic                  m_apb_presetn_i,
    input  logic [APB_AW-1:0]     read_write_addr_i,
    input  logic [NUM_SLAVES-1:0] read_write_sel_i,
    input  logic                  write_en_i,
    input  logic [APB_DW-1:0]     write_data_i,
    input  logic                  read_en_i,
    output logic [APB_DW-1:0]     read_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [APB_AW-1:0]     m_apb_paddr_o,
    output logic [NUM_SLAVES-1:0] m_apb_psel_o,
    output logic                  m_apb_penable_o,
    output logic                  m_apb_pwrite_o,
    output logic [APB_DW-1:0]     m_apb_pwdata_o,
    input  logic [APB_DW-1:0]     m_apb_prdata_i,
    input  logic                  m_apb_pready_i,
    input  logic                  m_apb_pslverr_i
);

    // A timeout of 0 disables the abort. The counter keeps one bit so that the
    // declaration stays legal.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                state_q, state_n;
    logic [CNT_W-1:0]      cnt_q, cnt_n;
    logic [APB_AW-1:0]     paddr_q, paddr_n;
    logic [NUM_SLAVES-1:0] psel_q, psel_n;
    logic                  penable_q, penable_n;
    logic                  pwrite_q, pwrite_n;
    logic [APB_DW-1:0]     pwdata_q, pwdata_n;
    logic [APB_DW-1:0]     rdata_q, rdata_n;
    logic                  busy_q, busy_n;
    logic                  done_q, done_n;
    logic                  error_q, error_n;
    logic [NUM_SLAVES-1:0] sel_lowest;
    logic                  req_any;

    assign sel_lowest = read_write_sel_i & (~read_write_sel_i + NUM_SLAVES'(1));
    assign req_any    = read_en_i | write_en_i;

    // Next-state and next-output logic. Each branch ending a transfer also
    // produces the completion status.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        paddr_n   = paddr_q;
        psel_n    = psel_q;
        penable_n = penable_q;
        pwrite_n  = pwrite_q;
        pwdata_n  = pwdata_q;
        rdata_n   = rdata_q;
        busy_n    = busy_q;
        done_n    = 1'b0;
        error_n   = error_q;

        case (state_q)
            IDLE: begin
                if (req_any && (|read_write_sel_i)) begin
                    state_n   = SETUP;
                    paddr_n   = read_write_addr_i;
                    psel_n    = sel_lowest;
                    penable_n = 1'b0;
                    pwrite_n  = write_en_i;
                    pwdata_n  = write_data_i;
                    busy_n    = 1'b1;
                    error_n   = 1'b0;
                end
            end

            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
                cnt_n     = '0;
            end

            ACCESS: begin
                if (m_apb_pready_i) begin
                    state_n   = RELEASE;
                    psel_n    = '0;
                    penable_n = 1'b0;
                    busy_n    = 1'b0;
                    done_n    = 1'b1;
                    error_n   = m_apb_pslverr_i;
                    if (!pwrite_q) begin
                        rdata_n = m_apb_prdata_i;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    state_n   = RELEASE;
                    psel_n    = '0;
                    penable_n = 1'b0;
                    busy_n    = 1'b0;
                    done_n    = 1'b1;
                    error_n   = 1'b1;
                    if (!pwrite_q) begin
                        rdata_n = '0;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end

            RELEASE: begin
                if (!req_any) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers. Reset clears everything, even mid-transfer.
    always_ff @(posedge m_apb_pclk_i or negedge m_apb_presetn_i) begin
        if (!m_apb_presetn_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            paddr_q   <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            paddr_q   <= paddr_n;
            psel_q    <= psel_n;
            penable_q <= penable_n;
            pwrite_q  <= pwrite_n;
            pwdata_q  <= pwdata_n;
            rdata_q   <= rdata_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            error_q   <= error_n;
        end
    end

    assign read_data_o     = rdata_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign error_o         = error_q;
    assign m_apb_paddr_o   = paddr_q;
    assign m_apb_psel_o    = psel_q;
    assign m_apb_penable_o = penable_q;
    assign m_apb_pwrite_o  = pwrite_q;
    assign m_apb_pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl
// Directed bench for apb_master_ctrl. The bench plays the APB slave by driving
// PREADY, PSLVERR and PRDATA by hand, and it checks hand-computed values cycle by cycle.

module tb_apb_master_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] addr = '0;
    logic [3:0]  sel = '0;
    logic        wr_en = 1'b0;
    logic [31:0] wdata = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] paddr;
    logic [3:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int testsRun = 0;
    int testsFailed = 0;

    apb_master_ctrl #(
        .APB_AW(32), .APB_DW(32), .NUM_SLAVES(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .m_apb_pclk_i      (clk),
        .m_apb_presetn_i   (rst_n),
        .read_write_addr_i (addr),
        .read_write_sel_i  (sel),
        .write_en_i        (wr_en),
        .write_data_i      (wdata),
        .read_en_i         (rd_en),
        .read_data_o       (rdata),
        .busy_o            (busy),
        .done_o            (done),
        .error_o           (error),
        .m_apb_paddr_o     (paddr),
        .m_apb_psel_o      (psel),
        .m_apb_penable_o   (penable),
        .m_apb_pwrite_o    (pwrite),
        .m_apb_pwdata_o    (pwdata),
        .m_apb_prdata_i    (prdata),
        .m_apb_pready_i    (pready),
        .m_apb_pslverr_i   (pslverr)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge
    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one request onto the bridge-side inputs
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [3:0] s, input logic [31:0] d);
        rd_en = rd;
        wr_en = wr;
        addr  = a;
        sel   = s;
        wdata = d;
    endtask

    // Compare one observed value against its expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        int accessCycles;
        bit gotDone;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_psel", 32'(psel), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_rdata", rdata, 32'h0);
        waitCycle();
        rst_n = 1'b1;
        waitCycle();

        // A request with no slave selected is ignored
        applyStimulus(1'b1, 1'b0, 32'h0000_0040, 4'b0000, 32'h0);
        waitCycle();
        waitCycle();
        checkOutput("nosel_psel", 32'(psel), 32'h0);
        checkOutput("nosel_busy", 32'(busy), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
        waitCycle();

        // Zero-wait read
        pready = 1'b1;
        prdata = 32'hA5A5_1234;
        applyStimulus(1'b1, 1'b0, 32'h0000_0004, 4'b0010, 32'h0);
        waitCycle();
        checkOutput("rd_c1_psel", 32'(psel), 32'h2);
        checkOutput("rd_c1_penable", 32'(penable), 32'h0);
        checkOutput("rd_c1_busy", 32'(busy), 32'h1);
        checkOutput("rd_c1_paddr", paddr, 32'h0000_0004);
        checkOutput("rd_c1_pwrite", 32'(pwrite), 32'h0);
        waitCycle();
        checkOutput("rd_c2_penable", 32'(penable), 32'h1);
        checkOutput("rd_c2_done", 32'(done), 32'h0);
        waitCycle();
        checkOutput("rd_c3_done", 32'(done), 32'h1);
        checkOutput("rd_c3_error", 32'(error), 32'h0);
        checkOutput("rd_c3_rdata", rdata, 32'hA5A5_1234);
        checkOutput("rd_c3_psel", 32'(psel), 32'h0);
        checkOutput("rd_c3_busy", 32'(busy), 32'h0);

        // Request held five cycles past done: no second transfer
        for (int i = 0; i < 5; i++) begin
            waitCycle();
            checkOutput("held_psel", 32'(psel), 32'h0);
            checkOutput("held_done", 32'(done), 32'h0);
            checkOutput("held_busy", 32'(busy), 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
        waitCycle();
        prdata = 32'h0000_BEEF;
        applyStimulus(1'b1, 1'b0, 32'h0000_0008, 4'b0001, 32'h0);
        waitCycle();
        checkOutput("rearm_psel", 32'(psel), 32'h1);
        checkOutput("rearm_paddr", paddr, 32'h0000_0008);
        waitCycle();
        waitCycle();
        checkOutput("rearm_done", 32'(done), 32'h1);
        checkOutput("rearm_rdata", rdata, 32'h0000_BEEF);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
        waitCycle();

        // Write with 3 wait states; both enables high, so write wins, and sel uses the lowest bit
        pready = 1'b0;
        prdata = 32'h1234_5678;
        applyStimulus(1'b1, 1'b1, 32'h0000_0010, 4'b1100, 32'hDEAD_BEEF);
        waitCycle();
        checkOutput("wr_c1_psel", 32'(psel), 32'h4);
        checkOutput("wr_c1_pwrite", 32'(pwrite), 32'h1);
        checkOutput("wr_c1_pwdata", pwdata, 32'hDEAD_BEEF);
        wdata = 32'h0;
        waitCycle();
        checkOutput("wr_c2_penable", 32'(penable), 32'h1);
        waitCycle();
        waitCycle();
        checkOutput("wr_c4_pwdata", pwdata, 32'hDEAD_BEEF);
        checkOutput("wr_c4_done", 32'(done), 32'h0);
        waitCycle();
        checkOutput("wr_c5_penable", 32'(penable), 32'h1);
        pready = 1'b1;
        waitCycle();
        checkOutput("wr_c6_done", 32'(done), 32'h1);
        checkOutput("wr_c6_error", 32'(error), 32'h0);
        checkOutput("wr_c6_rdata", rdata, 32'h0000_BEEF);
        checkOutput("wr_c6_pwdata", pwdata, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
        waitCycle();

        // PSLVERR read
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'h0000_0011;
        applyStimulus(1'b1, 1'b0, 32'h0000_000C, 4'b0100, 32'h0);
        waitCycle();
        waitCycle();
        waitCycle();
        checkOutput("slverr_done", 32'(done), 32'h1);
        checkOutput("slverr_error", 32'(error), 32'h1);
        checkOutput("slverr_rdata", rdata, 32'h0000_0011);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
        pslverr = 1'b0;
        waitCycle();
        checkOutput("slverr_error_held", 32'(error), 32'h1);

        // Timeout: PREADY stuck low
        pready = 1'b0;
        prdata = 32'hFFFF_FFFF;
        applyStimulus(1'b1, 1'b0, 32'h0000_0030, 4'b0001, 32'h0);
        waitCycle();
        checkOutput("to_error_cleared", 32'(error), 32'h0);
        accessCycles = 0;
        gotDone = 1'b0;
        for (int i = 0; i < 40 && !gotDone; i++) begin
            if (penable && (psel != 4'b0000)) accessCycles++;
            waitCycle();
            if (done) gotDone = 1'b1;
        end
        checkOutput("to_done_seen", 32'(gotDone), 32'h1);
        checkOutput("to_access_cycles", 32'(accessCycles), 32'd16);
        checkOutput("to_error", 32'(error), 32'h1);
        checkOutput("to_rdata", rdata, 32'h0);
        checkOutput("to_psel", 32'(psel), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
        waitCycle();

        // Reset while in ACCESS
        applyStimulus(1'b0, 1'b1, 32'h0000_0050, 4'b0010, 32'h0BAD_F00D);
        waitCycle();
        waitCycle();
        checkOutput("rstacc_penable_pre", 32'(penable), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstacc_psel", 32'(psel), 32'h0);
        checkOutput("rstacc_penable", 32'(penable), 32'h0);
        checkOutput("rstacc_busy", 32'(busy), 32'h0);
        checkOutput("rstacc_done", 32'(done), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
        waitCycle();
        rst_n = 1'b1;
        waitCycle();
        checkOutput("rstacc_done_after", 32'(done), 32'h0);
        pready = 1'b1;
        prdata = 32'h5555_AAAA;
        applyStimulus(1'b1, 1'b0, 32'h0000_0020, 4'b1000, 32'h0);
        waitCycle();
        checkOutput("post_rst_psel", 32'(psel), 32'h8);
        waitCycle();
        waitCycle();
        checkOutput("post_rst_done", 32'(done), 32'h1);
        checkOutput("post_rst_rdata", rdata, 32'h5555_AAAA);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
        waitCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
